h80cpu_uart_rx: RTL

Serial receiver for the h80cpu I/O subsystem and the receive counterpart of the existing UART transmit path on `uart_txp`. It deserialises 8N1 frames from an idle-high line, buffers received bytes in a small first-word-fall-through FIFO, and reports framing and overrun errors as sticky flags. It runs entirely in the `sysclk` domain. The I/O decoder reads it through a simple read-strobe interface.

---
 rtl/h80cpu_uart_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/h80cpu_uart_rx.sv
// 8N1 serial receiver for the h80cpu I/O subsystem: 2-flop synchronizer, bit-timing FSM,
// FWFT receive FIFO and sticky overrun / framing-error flags, all in the sysclk domain.
module h80cpu_uart_rx #(
    parameter int SYSCLK_FREQ = 27000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            sysclk,
    input  logic                            reset_n,
    input  logic                            uart_rxp,
    input  logic                            rd_en,
    input  logic                            err_clr,
    output logic [7:0]                      rd_data,
    output logic                            rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overrun,
    output logic                            frame_err
);

    localparam int CLKS_PER_BIT = SYSCLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNTF_W       = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_overrun;
    logic               r_frame_err;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNTF_W-1:0]  r_count;

    logic               w_rx_s;
    logic               w_cnt_zero;
    logic               w_stop_sample;
    logic               w_push_req;
    logic               w_full;
    logic               w_pop;
    logic               w_push;

    assign w_rx_s        = r_sync2;
    assign w_cnt_zero    = (r_bit_cnt == '0);
    assign w_stop_sample = (r_state == S_STOP) && w_cnt_zero;
    assign w_push_req    = w_stop_sample && w_rx_s;
    assign w_full        = (r_count == CNTF_W'(FIFO_DEPTH));
    assign w_pop         = rd_en && (r_count != '0);
    // A full FIFO still accepts the byte when the head is popped in the same cycle.
    assign w_push        = w_push_req && (!w_full || w_pop);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rxp;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_bit_cnt <= CNT_W'(CLKS_PER_BIT / 2 - 1);
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_cnt_zero) begin
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_bit_cnt <= CNT_W'(CLKS_PER_BIT - 1);
                            r_bit_idx <= '0;
                            r_state   <= S_DATA;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_cnt_zero) begin
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_cnt <= CNT_W'(CLKS_PER_BIT - 1);
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_cnt_zero) begin
                        r_state <= w_rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
                S_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Setting wins over a simultaneous clear.
            if (w_stop_sample && !w_rx_s) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end

            if (w_push_req && !w_push) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data    = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
    assign rx_ready   = (r_count != '0);
    assign fifo_count = r_count;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;

endmodule
